reg_file_sb: RTL and testbench
==============================

Name: reg_file_sb

Overview:
- Parametrised multi-read register file with an integrated per-register busy scoreboard for the pipelined 21-bit softcore.
- One write port (writeback stage) and two asynchronous read ports (decode stage).
- An issue port reserves a destination register. The scoreboard flags read-after-write and write-after-write hazards so decode can stall.
- Replaces the fixed 8x21 tristate-mux register file; read muxing is plain multiplexers, with no tristates.

Parameters:
- WIDTH, 21, data width of each register in bits.
- DEPTH, 8, number of registers; must be a power of two, >= 2.
- AW, $clog2(DEPTH), address width (derived; not to be overridden).

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst  input  1  asynchronous active-high reset.
- wr_en  input  1  writeback strobe.
- wr_addr  input  AW  writeback destination register.
- wr_data  input  WIDTH  writeback data.
- rd0_addr  input  AW  read port 0 address.
- rd0_data  output  WIDTH  read port 0 data (combinational).
- rd0_busy  output  1  register at rd0_addr has a pending write.
- rd1_addr  input  AW  read port 1 address.
- rd1_data  output  WIDTH  read port 1 data (combinational).
- rd1_busy  output  1  register at rd1_addr has a pending write.
- iss_en  input  1  request to reserve iss_addr as an in-flight destination.
- iss_addr  input  AW  destination to reserve.
- iss_stall  output  1  reservation refused this cycle (destination already busy).
- busy_vec  output  DEPTH  full scoreboard, bit i = register i busy.
- flush  input  1  synchronous clear of all busy bits (pipeline flush); register contents are untouched.

Behaviour:
- Reset (rst=1, asynchronous, no clock needed): all DEPTH registers = 0, busy_vec = 0. Consequently rd0_data = rd1_data = 0, rd0_busy = rd1_busy = 0, iss_stall = 0. Reset asserted mid-operation aborts any pending reservation or write in that cycle.
- Write: on a clk rise with wr_en=1, reg[wr_addr] <= wr_data and busy[wr_addr] <= 0. Writing a non-busy register is legal; data is updated and busy stays 0.
- Read: rdN_data = reg[rdN_addr], purely combinational, zero latency. Both ports may address the same register.
- rdN_busy = busy[rdN_addr] (registered busy state; see the WR_BYPASS_EN feature).
- iss_stall = iss_en & busy[iss_addr], combinational.
- Issue: on a clk rise with iss_en=1 and iss_stall=0, busy[iss_addr] <= 1. With iss_stall=1 the scoreboard is unchanged; the requester holds iss_en/iss_addr until accepted.
- Simultaneous writeback and issue to the same address:
  - iss_stall is evaluated on the pre-edge busy bit.
  - If the issue is accepted, set wins: data is written and busy ends at 1 (the new producer owns the register).
  - If stalled, the writeback clears busy; the retried issue is accepted next cycle.
- Writeback and issue to different addresses update independently in the same cycle.
- flush=1 on a clk rise: busy_vec <= 0, overriding any same-cycle issue. A same-cycle write still updates data.
- Priority per busy bit: rst > flush > accepted issue (set) > wr_en (clear).
- No X propagation: all addresses are in range by construction (DEPTH = 2^AW).

Optional Feature:
- Macro: REG_FILE_SB_WR_BYPASS_EN.
- Defined:
  - If wr_en=1 and rdN_addr==wr_addr in the same cycle, rdN_data = wr_data and rdN_busy = 0 (write-through forwarding).
  - iss_stall also treats busy[iss_addr] as 0 when wr_en & (wr_addr==iss_addr), so the issue is accepted that cycle and busy ends at 1.
- Undefined:
  - Reads return stored contents; the new value is visible the cycle after the write edge.
  - rdN_busy and iss_stall use only the registered busy bit.

Test Plan:
1. Reset then read all: rst pulse, sweep rd0_addr/rd1_addr 0..7 -> data 0, busy 0, busy_vec=8'h00.
2. Write/read: wr_en, addr 3, data 21'h1ABCDE; next cycle rd0_addr=3, rd1_addr=3 -> both 21'h1ABCDE. Other registers remain 0.
3. Scoreboard: issue addr 5 -> busy_vec=8'h20, rd1_busy=1 at addr 5. Second issue to 5 -> iss_stall=1, busy_vec unchanged. Writeback 5 with 21'h00042 -> busy_vec=8'h00, rd1_data=21'h00042.
4. Same-cycle writeback 2 and accepted issue 2 (busy[2]=0 beforehand) -> reg2 updated, busy_vec=8'h04. Repeat with busy[2]=1 -> iss_stall=1, busy_vec=8'h00 after the edge.
5. Flush: busy_vec=8'hF0, flush with same-cycle iss_en addr 1 -> busy_vec=8'h00. rst asserted mid-cycle between edges -> all outputs 0 immediately.
6. Bypass: wr_en addr 6, data 21'h0F0F0, rd0_addr=6 same cycle -> rd0_data=21'h0F0F0 with the macro defined, previous value without it.

Source files
------------

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-read register file with a per-register busy scoreboard.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data  writeback port (stores data, clears busy)
//   rd0_addr/rd0_data/rd0_busy  read port 0 (combinational data + busy)
//   rd1_addr/rd1_data/rd1_busy  read port 1 (combinational data + busy)
//   iss_en/iss_addr/iss_stall  destination reservation; stall when already busy
//   busy_vec             full scoreboard, bit i = register i busy
//   flush                synchronous clear of all busy bits (data untouched)
//
// Optional feature: define REG_FILE_SB_WR_BYPASS_EN for write-through
// forwarding onto the read ports and a same-cycle writeback release for issue.
module reg_file_sb #(
  parameter int unsigned WIDTH = 21,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]    rd0_addr,
  output logic [WIDTH-1:0] rd0_data,
  output logic             rd0_busy,
  input  logic [AW-1:0]    rd1_addr,
  output logic [WIDTH-1:0] rd1_data,
  output logic             rd1_busy,
  input  logic             iss_en,
  input  logic [AW-1:0]    iss_addr,
  output logic             iss_stall,
  output logic [DEPTH-1:0] busy_vec,
  input  logic             flush
);

  logic [WIDTH-1:0] regs_q [DEPTH];
  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;
  logic             iss_busy;
  logic             iss_acc;

  // Busy bit seen by the issue check; a same-cycle writeback may release it.
`ifdef REG_FILE_SB_WR_BYPASS_EN
  assign iss_busy = busy_q[iss_addr] & ~(wr_en & (wr_addr == iss_addr));
`else
  assign iss_busy = busy_q[iss_addr];
`endif

  assign iss_stall = iss_en & iss_busy;
  assign iss_acc   = iss_en & ~iss_busy;
  assign busy_vec  = busy_q;

  // Scoreboard next state, lowest to highest priority: clear, set, flush.
  always_comb begin
    busy_d = busy_q;
    if (wr_en) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (iss_acc) begin
      busy_d[iss_addr] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
  end

  // Scoreboard state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Register storage; flush never touches contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Read ports: plain muxes, optionally forwarding the in-flight writeback.
`ifdef REG_FILE_SB_WR_BYPASS_EN
  logic rd0_fwd;
  logic rd1_fwd;
  assign rd0_fwd  = wr_en & (rd0_addr == wr_addr);
  assign rd1_fwd  = wr_en & (rd1_addr == wr_addr);
  assign rd0_data = rd0_fwd ? wr_data : regs_q[rd0_addr];
  assign rd1_data = rd1_fwd ? wr_data : regs_q[rd1_addr];
  assign rd0_busy = busy_q[rd0_addr] & ~rd0_fwd;
  assign rd1_busy = busy_q[rd1_addr] & ~rd1_fwd;
`else
  assign rd0_data = regs_q[rd0_addr];
  assign rd1_data = regs_q[rd1_addr];
  assign rd0_busy = busy_q[rd0_addr];
  assign rd1_busy = busy_q[rd1_addr];
`endif

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: directed self-checking bench for reg_file_sb (8 x 21).
module tb_reg_file_sb;

  localparam int unsigned WIDTH = 21;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 3;

  logic             clk;
  logic             rst;
  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [AW-1:0]    rd0_addr;
  logic [WIDTH-1:0] rd0_data;
  logic             rd0_busy;
  logic [AW-1:0]    rd1_addr;
  logic [WIDTH-1:0] rd1_data;
  logic             rd1_busy;
  logic             iss_en;
  logic [AW-1:0]    iss_addr;
  logic             iss_stall;
  logic [DEPTH-1:0] busy_vec;
  logic             flush;

  int checks = 0;
  int errors = 0;

  reg_file_sb #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd0_addr (rd0_addr),
    .rd0_data (rd0_data),
    .rd0_busy (rd0_busy),
    .rd1_addr (rd1_addr),
    .rd1_data (rd1_data),
    .rd1_busy (rd1_busy),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .iss_stall(iss_stall),
    .busy_vec (busy_vec),
    .flush    (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    rd0_addr = '0; rd1_addr = '0; iss_en = 1'b0; iss_addr = '0; flush = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      rd0_addr = AW'(i);
      rd1_addr = AW'(7 - i);
      #1;
      checks++;
      if (rd0_data !== 21'h0 || rd1_data !== 21'h0) begin
        errors++;
        $display("FAIL reset_data[%0d] got rd0=%h rd1=%h exp 0", i, rd0_data, rd1_data);
      end
      checks++;
      if (rd0_busy !== 1'b0 || rd1_busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_busy[%0d] got rd0=%b rd1=%b exp 0", i, rd0_busy, rd1_busy);
      end
    end
    checks++;
    if (busy_vec !== 8'h00 || iss_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_vec got busy_vec=%h iss_stall=%b exp 00/0", busy_vec, iss_stall);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 21'h1ABCDE;
    tick();
    wr_en = 1'b0;
    rd0_addr = 3'd3; rd1_addr = 3'd3;
    #1;
    checks++;
    if (rd0_data !== 21'h1ABCDE || rd1_data !== 21'h1ABCDE) begin
      errors++;
      $display("FAIL write_read got rd0=%h rd1=%h exp 1abcde", rd0_data, rd1_data);
    end
    rd0_addr = 3'd2; rd1_addr = 3'd4;
    #1;
    checks++;
    if (rd0_data !== 21'h0 || rd1_data !== 21'h0) begin
      errors++;
      $display("FAIL write_others got rd0=%h rd1=%h exp 0", rd0_data, rd1_data);
    end
    checks++;
    if (busy_vec !== 8'h00) begin
      errors++;
      $display("FAIL write_nonbusy got busy_vec=%h exp 00", busy_vec);
    end
  endtask

  task automatic test_scoreboard();
    iss_en = 1'b1; iss_addr = 3'd5;
    #1;
    checks++;
    if (iss_stall !== 1'b0) begin
      errors++;
      $display("FAIL sb_first_issue got iss_stall=%b exp 0", iss_stall);
    end
    tick();
    iss_en = 1'b0;
    rd1_addr = 3'd5; rd0_addr = 3'd4;
    #1;
    checks++;
    if (busy_vec !== 8'h20 || rd1_busy !== 1'b1 || rd0_busy !== 1'b0) begin
      errors++;
      $display("FAIL sb_busy got busy_vec=%h rd1_busy=%b rd0_busy=%b exp 20/1/0",
               busy_vec, rd1_busy, rd0_busy);
    end
    iss_en = 1'b1; iss_addr = 3'd5;
    #1;
    checks++;
    if (iss_stall !== 1'b1) begin
      errors++;
      $display("FAIL sb_second_issue got iss_stall=%b exp 1", iss_stall);
    end
    tick();
    iss_en = 1'b0;
    checks++;
    if (busy_vec !== 8'h20) begin
      errors++;
      $display("FAIL sb_stall_hold got busy_vec=%h exp 20", busy_vec);
    end
    wr_en = 1'b1; wr_addr = 3'd5; wr_data = 21'h00042;
    tick();
    wr_en = 1'b0;
    #1;
    checks++;
    if (busy_vec !== 8'h00 || rd1_data !== 21'h00042 || rd1_busy !== 1'b0) begin
      errors++;
      $display("FAIL sb_writeback got busy_vec=%h rd1=%h rd1_busy=%b exp 00/00042/0",
               busy_vec, rd1_data, rd1_busy);
    end
  endtask

  task automatic test_same_cycle();
    // Accepted issue plus writeback to the same register: set wins.
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 21'h12345;
    iss_en = 1'b1; iss_addr = 3'd2;
    #1;
    checks++;
    if (iss_stall !== 1'b0) begin
      errors++;
      $display("FAIL same_acc_stall got %b exp 0", iss_stall);
    end
    tick();
    wr_en = 1'b0; iss_en = 1'b0; rd0_addr = 3'd2;
    #1;
    checks++;
    if (busy_vec !== 8'h04 || rd0_data !== 21'h12345) begin
      errors++;
      $display("FAIL same_acc got busy_vec=%h rd0=%h exp 04/12345", busy_vec, rd0_data);
    end
    // Register 2 now busy: writeback plus issue again.
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 21'h054321;
    iss_en = 1'b1; iss_addr = 3'd2;
    #1;
`ifdef REG_FILE_SB_WR_BYPASS_EN
    checks++;
    if (iss_stall !== 1'b0) begin
      errors++;
      $display("FAIL same_busy_stall got %b exp 0", iss_stall);
    end
    tick();
    wr_en = 1'b0; iss_en = 1'b0;
    #1;
    checks++;
    if (busy_vec !== 8'h04 || rd0_data !== 21'h054321) begin
      errors++;
      $display("FAIL same_busy got busy_vec=%h rd0=%h exp 04/054321", busy_vec, rd0_data);
    end
`else
    checks++;
    if (iss_stall !== 1'b1) begin
      errors++;
      $display("FAIL same_busy_stall got %b exp 1", iss_stall);
    end
    tick();
    wr_en = 1'b0;
    #1;
    checks++;
    if (busy_vec !== 8'h00 || rd0_data !== 21'h054321) begin
      errors++;
      $display("FAIL same_busy got busy_vec=%h rd0=%h exp 00/054321", busy_vec, rd0_data);
    end
    // Held issue is accepted on the retry.
    checks++;
    if (iss_stall !== 1'b0) begin
      errors++;
      $display("FAIL same_retry_stall got %b exp 0", iss_stall);
    end
    tick();
    iss_en = 1'b0;
    checks++;
    if (busy_vec !== 8'h04) begin
      errors++;
      $display("FAIL same_retry got busy_vec=%h exp 04", busy_vec);
    end
`endif
  endtask

  task automatic test_independent();
    // Writeback to 2 (busy) and issue to 7 in the same cycle.
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 21'h00777;
    iss_en = 1'b1; iss_addr = 3'd7;
    tick();
    wr_en = 1'b0; iss_en = 1'b0;
    checks++;
    if (busy_vec !== 8'h80) begin
      errors++;
      $display("FAIL indep got busy_vec=%h exp 80", busy_vec);
    end
  endtask

  task automatic test_flush();
    for (int i = 4; i < 8; i++) begin
      iss_en = 1'b1; iss_addr = AW'(i);
      tick();
    end
    iss_en = 1'b0;
    checks++;
    if (busy_vec !== 8'hF0) begin
      errors++;
      $display("FAIL flush_setup got busy_vec=%h exp f0", busy_vec);
    end
    flush = 1'b1; iss_en = 1'b1; iss_addr = 3'd1;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 21'h1FFFFF;
    tick();
    flush = 1'b0; iss_en = 1'b0; wr_en = 1'b0;
    rd0_addr = 3'd0;
    #1;
    checks++;
    if (busy_vec !== 8'h00 || rd0_data !== 21'h1FFFFF) begin
      errors++;
      $display("FAIL flush got busy_vec=%h rd0=%h exp 00/1fffff", busy_vec, rd0_data);
    end
    // Async reset between edges clears everything immediately.
    iss_en = 1'b1; iss_addr = 3'd3;
    tick();
    checks++;
    if (busy_vec !== 8'h08) begin
      errors++;
      $display("FAIL rst_setup got busy_vec=%h exp 08", busy_vec);
    end
    rd1_addr = 3'd3;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (busy_vec !== 8'h00 || rd0_data !== 21'h0 || rd1_data !== 21'h0 ||
        rd1_busy !== 1'b0 || iss_stall !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got busy_vec=%h rd0=%h rd1=%h rd1_busy=%b iss_stall=%b exp all 0",
               busy_vec, rd0_data, rd1_data, rd1_busy, iss_stall);
    end
    iss_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_bypass();
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 21'h11111;
    tick();
    wr_data = 21'h0F0F0; rd0_addr = 3'd6;
    #1;
    checks++;
`ifdef REG_FILE_SB_WR_BYPASS_EN
    if (rd0_data !== 21'h0F0F0) begin
      errors++;
      $display("FAIL bypass got rd0=%h exp 0f0f0", rd0_data);
    end
`else
    if (rd0_data !== 21'h11111) begin
      errors++;
      $display("FAIL bypass got rd0=%h exp 11111", rd0_data);
    end
`endif
    tick();
    wr_en = 1'b0;
    #1;
    checks++;
    if (rd0_data !== 21'h0F0F0) begin
      errors++;
      $display("FAIL bypass_after got rd0=%h exp 0f0f0", rd0_data);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_scoreboard();
    test_same_cycle();
    test_independent();
    test_flush();
    test_bypass();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
